// File: rtl/result_collector.sv
// result_collector: reads OUTPUT_NODE score words from the result BRAM,
// starting at BASE_ADDR, and packs them into one flat vector with node 0
// in the MSB slice. Optional signed argmax over the scores is built when
// RESULT_ARGMAX_EN is defined; otherwise class_idx/class_val are tied to 0.
//
// Handshake: start is sampled only while idle. busy is high from the edge
// that accepts start up to the edge that raises done. done is a one-cycle
// pulse that also marks result/class_idx/class_val as final.
//
// Per node the BRAM enable is high for READ_LATENCY cycles. The capture edge
// (leaving WAIT) samples bram_douta and drops the enable. The following
// CAPTURE cycle either re-issues the next node or finishes. This gives a
// spacing of READ_LATENCY+1 edges per node.
`timescale 1ns/1ps
module result_collector #(
  parameter int DATA_SIZE    = 8,
  parameter int OUTPUT_NODE  = 10,
  parameter int ADDR_WIDTH   = 15,
  parameter int BASE_ADDR    = 18900,
  parameter int READ_LATENCY = 3,
  parameter int IDX_WIDTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DATA_SIZE-1:0]             bram_douta,
  output logic                             bram_ena,
  output logic [ADDR_WIDTH-1:0]            bram_addra,
  output logic [DATA_SIZE*OUTPUT_NODE-1:0] result,
  output logic [IDX_WIDTH-1:0]             class_idx,
  output logic [DATA_SIZE-1:0]             class_val,
  output logic                             busy,
  output logic                             done
);

  localparam int K_W   = $clog2(OUTPUT_NODE + 1);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] wait_cnt;
  logic             issue_now, capture_now, finish_now;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the per-cycle action strobes.
  always_comb begin
    state_nxt   = state;
    issue_now   = 1'b0;
    capture_now = 1'b0;
    finish_now  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue_now = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == CNT_W'(READ_LATENCY - 1)) begin
          capture_now = 1'b1;
          state_nxt   = CAPTURE;
        end
      end
      CAPTURE: begin
        // k already counts the captured nodes here.
        if (k == K_W'(OUTPUT_NODE)) begin
          finish_now = 1'b1;
          state_nxt  = IDLE;
        end else begin
          issue_now = 1'b1;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // BRAM request, wait counter, node counter, packed result and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_ena   <= 1'b0;
      bram_addra <= '0;
      result     <= '0;
      k          <= '0;
      wait_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= finish_now;
      if (state == IDLE && start) k <= '0;
      if (issue_now) begin
        bram_ena   <= 1'b1;
        bram_addra <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(k);
        wait_cnt   <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (capture_now) begin
        bram_ena <= 1'b0;
        k        <= k + 1'b1;
        for (int i = 0; i < OUTPUT_NODE; i++) begin
          if (k == K_W'(i))
            result[DATA_SIZE*(OUTPUT_NODE-i)-1 -: DATA_SIZE] <= bram_douta;
        end
      end
    end
  end

`ifdef RESULT_ARGMAX_EN
  // Running signed maximum; node 0 seeds it, later nodes replace it only
  // when strictly greater so the lowest index wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      class_idx <= '0;
      class_val <= '0;
    end else if (capture_now &&
                 (k == '0 || $signed(bram_douta) > $signed(class_val))) begin
      class_idx <= IDX_WIDTH'(k);
      class_val <= bram_douta;
    end
  end
`else
  assign class_idx = '0;
  assign class_val = '0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: a default-parameter instance (L=3, N=10) and
// a small instance (L=1, N=4, base address near the top of the space so
// the read address wraps). Directed score patterns are loaded into a shared
// BRAM model. Expected results are queued when start is driven, and
// monitors pop and compare them whenever done pulses.
`timescale 1ns/1ps
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic [7:0]  douta, douta2;
  logic        ena, ena2, busy, busy2, done, done2;
  logic [14:0] addr, addr2;
  logic [79:0] res;
  logic [31:0] res2;
  logic [3:0]  cidx, cidx2;
  logic [7:0]  cval, cval2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected-response queues for the main and small instances.
  logic [79:0] exp_res_q[$];
  logic [3:0]  exp_idx_q[$];
  logic [7:0]  exp_val_q[$];
  logic [31:0] exp_edge_q[$];
  logic [31:0] exp2_res_q[$];
  logic [3:0]  exp2_idx_q[$];
  logic [7:0]  exp2_val_q[$];
  logic [31:0] exp2_edge_q[$];
  logic [14:0] exp_addr_q[$];

  logic [7:0] mem [0:32767];
  logic [7:0] pipe0 = 8'hEE;
  logic [7:0] pipe1 = 8'hEE;

  result_collector dut (
    .clk(clk), .rst(rst), .start(start), .bram_douta(douta),
    .bram_ena(ena), .bram_addra(addr), .result(res),
    .class_idx(cidx), .class_val(cval), .busy(busy), .done(done)
  );

  result_collector #(
    .OUTPUT_NODE(4), .BASE_ADDR(32766), .READ_LATENCY(1)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bram_douta(douta2),
    .bram_ena(ena2), .bram_addra(addr2), .result(res2),
    .class_idx(cidx2), .class_val(cval2), .busy(busy2), .done(done2)
  );

  // Clock and edge counter: after edge X, cyc == X.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models: 3-cycle pipelined read for the main instance, direct read
  // for the latency-1 instance. Data outside an enabled read reads as 0xEE.
  always @(posedge clk) begin
    pipe0 <= ena ? mem[addr] : 8'hEE;
    pipe1 <= pipe0;
  end
  assign douta  = pipe1;
  assign douta2 = ena2 ? mem[addr2] : 8'hEE;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Main-instance monitor: done checks plus enable pulse width.
  int  hi_cnt   = 0;
  logic prev_ena = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_edge_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done got=1 expected=0 at cycle %0d", cyc);
        end else begin
          chk("done_edge", 128'(cyc), 128'(exp_edge_q.pop_front()));
          chk("result", res, exp_res_q.pop_front());
          chk("class_idx", cidx, exp_idx_q.pop_front());
          chk("class_val", cval, exp_val_q.pop_front());
          chk("busy_at_done", busy, 0);
        end
      end
      if (prev_ena && !ena) chk("ena_width", 128'(hi_cnt), 3);
    end
    hi_cnt   = ena ? (prev_ena ? hi_cnt + 1 : 1) : 0;
    prev_ena = ena;
  end

  // Small-instance monitor: issued addresses and done checks.
  logic prev_ena2 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ena2 && !prev_ena2) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue got=%0d expected=none", addr2);
        end else chk("addr2", addr2, exp_addr_q.pop_front());
      end
      if (done2) begin
        if (exp2_edge_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done2 got=1 expected=0 at cycle %0d", cyc);
        end else begin
          chk("done2_edge", 128'(cyc), 128'(exp2_edge_q.pop_front()));
          chk("result2", res2, exp2_res_q.pop_front());
          chk("class_idx2", cidx2, exp2_idx_q.pop_front());
          chk("class_val2", cval2, exp2_val_q.pop_front());
        end
      end
    end
    prev_ena2 = ena2;
  end

  task automatic load10(input logic [79:0] v);
    for (int i = 0; i < 10; i++) mem[18900 + i] = v[79 - 8*i -: 8];
  endtask

  // Queue expectations; without the argmax build the class outputs stay 0.
  task automatic push_exp(input logic [79:0] r, input logic [3:0] i,
                          input logic [7:0] v, input int done_edge);
    exp_res_q.push_back(r);
`ifdef RESULT_ARGMAX_EN
    exp_idx_q.push_back(i);
    exp_val_q.push_back(v);
`else
    exp_idx_q.push_back(4'd0);
    exp_val_q.push_back(8'd0);
`endif
    exp_edge_q.push_back(32'(done_edge));
  endtask

  // Single start pulse; edge 0 is the next posedge (cyc+1).
  // Done is expected N(L+1)+1 = 41 edges after edge 0.
  task automatic run_main(input logic [79:0] r, input logic [3:0] i,
                          input logic [7:0] v);
    @(negedge clk); #1;
    push_exp(r, i, v, cyc + 1 + 41);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_queues();
    exp_res_q.delete(); exp_idx_q.delete(); exp_val_q.delete();
    exp_edge_q.delete(); exp2_res_q.delete(); exp2_idx_q.delete();
    exp2_val_q.delete(); exp2_edge_q.delete(); exp_addr_q.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_edge_q.size() != 0 || exp2_edge_q.size() != 0 ||
            exp_addr_q.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_edge_q.size() != 0 || exp2_edge_q.size() != 0 ||
        exp_addr_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d_pending expected=0",
               exp_edge_q.size() + exp2_edge_q.size() + exp_addr_q.size());
      clear_queues();
    end
  endtask

  initial begin
    int x;
    for (int a = 0; a < 32768; a++) mem[a] = 8'hEE;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;

    // Reset values.
    @(negedge clk); #1;
    chk("rst_ena", ena, 0);
    chk("rst_addr", addr, 0);
    chk("rst_result", res, 0);
    chk("rst_idx", cidx, 0);
    chk("rst_val", cval, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ena2", ena2, 0);
    chk("rst_addr2", addr2, 0);

    // Mixed scores: tie on 0x7F resolves to index 2; 0x80 is negative.
    load10(80'h05117F80_0000000000_7F);
    run_main(80'h05117F80_0000000000_7F, 4'd2, 8'h7F);
    drain(100);

    // All equal negative scores: node 0 seeds and keeps the maximum.
    load10({10{8'hF0}});
    run_main({10{8'hF0}}, 4'd0, 8'hF0);
    drain(100);

    // All-negative scores: -1 first seen at index 2 (also at 7).
    load10(80'h8090FFFE_8085C0FFA090);
    @(negedge clk); #1;
    x = cyc;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    // Reset asserted so that the edge 15 of this collection samples it.
    while (cyc < x + 15) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_ena", ena, 0);
    chk("abort_addr", addr, 0);
    chk("abort_result", res, 0);
    chk("abort_idx", cidx, 0);
    chk("abort_val", cval, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    clear_queues();
    run_main(80'h8090FFFE_8085C0FFA090, 4'd2, 8'hFF);
    drain(100);

    // Small instance: address wraps 32766, 32767, 0, 1; done at edge 9.
    mem[32766] = 8'h12; mem[32767] = 8'h34; mem[0] = 8'h56; mem[1] = 8'h9A;
    exp_addr_q.push_back(15'd32766);
    exp_addr_q.push_back(15'd32767);
    exp_addr_q.push_back(15'd0);
    exp_addr_q.push_back(15'd1);
    @(negedge clk); #1;
    exp2_res_q.push_back(32'h1234569A);
`ifdef RESULT_ARGMAX_EN
    exp2_idx_q.push_back(4'd2);
    exp2_val_q.push_back(8'h56);
`else
    exp2_idx_q.push_back(4'd0);
    exp2_val_q.push_back(8'h00);
`endif
    exp2_edge_q.push_back(32'(cyc + 1 + 9));
    start2 = 1'b1;
    @(negedge clk); #1;
    start2 = 1'b0;
    drain(40);

    // Start pulses while busy are ignored; result holds until overwritten.
    load10(80'h05117F80_0000000000_7F);
    @(negedge clk); #1;
    x = cyc;
    push_exp(80'h05117F80_0000000000_7F, 4'd2, 8'h7F, x + 1 + 41);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    chk("result_held_on_start", res, 80'h8090FFFE_8085C0FFA090);
    chk("busy_mid", busy, 1);
    for (int p = 0; p < 3; p++) begin
      repeat (7 + 3*p) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
    end
    drain(100);
    repeat (50) @(negedge clk);

    // Start held high: a start sampled while done is high is taken at the
    // edge that lowers done, so collections repeat every 41+1 edges.
    @(negedge clk); #1;
    x = cyc;
    for (int r = 0; r < 3; r++)
      push_exp(80'h05117F80_0000000000_7F, 4'd2, 8'h7F, x + 1 + 41 + 42*r);
    start = 1'b1;
    while (cyc < x + 1 + 41 + 84 && cyc < x + 400) begin @(negedge clk); #1; end
    start = 1'b0;
    drain(20);
    repeat (50) @(negedge clk);
    chk("idle_after_hold", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
